// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_cmd_pkg;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_LOAD        = 3'd1,
      ST_WAIT_CS     = 3'd2,
      ST_WAIT_CS_LOW = 3'd3,
      ST_GAP         = 3'd4
   } state_t;

   // Serializer DelAttSelect encodings
   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_ATT  = 2'b01;
   localparam logic [1:0] SEL_DEL  = 2'b10;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding {sel, data} command entries.
module spi_cmd_fifo #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == CW'(0));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Next storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Entry storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues {data, select} commands and issues them one at a time to the SPI serializer.
module spi_cmd_sequencer
   import spi_cmd_pkg::*;
#(
   parameter int unsigned REG_WIDTH      = 32,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned LD_CYCLES      = 4,
   parameter int unsigned GAP_CYCLES     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [REG_WIDTH-1:0]        cmd_data,
   input  logic [1:0]                  cmd_sel,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   output logic [REG_WIDTH-1:0]        ser_data,
   output logic                        ser_ld,
   output logic [1:0]                  ser_sel,
   input  logic                        ser_att_cs,
   input  logic                        ser_del_cs,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        done_pulse,
   output logic                        err_timeout,
   output logic                        err_bad_sel,
   input  logic                        err_clear
);

   localparam int unsigned ENT_W = REG_WIDTH + 2;
   localparam int unsigned LD_W  = $clog2(LD_CYCLES) + 1;
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LD_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   state_t               state_q, state_d;
   logic [LD_W-1:0]      ld_cnt_q, ld_cnt_d;
   logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [REG_WIDTH-1:0] ser_data_q, ser_data_d;
   logic                 ser_ld_q, ser_ld_d;
   logic [1:0]           ser_sel_q, ser_sel_d;
   logic                 done_pulse_q, done_pulse_d;
   logic                 err_timeout_q, err_timeout_d;
   logic                 err_bad_sel_q, err_bad_sel_d;
   logic                 head_seen_q, head_seen_d;

   logic [ENT_W-1:0]     fifo_rdata;
   logic                 fifo_full, fifo_empty, fifo_pop_c;
   logic                 set_timeout_c, set_bad_sel_c, enter_gap_c, cs_any_c;
   logic [REG_WIDTH-1:0] head_data;
   logic [1:0]           head_sel;

   spi_cmd_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (cmd_valid),
      .wdata  ({cmd_sel, cmd_data}),
      .pop    (fifo_pop_c),
      .rdata  (fifo_rdata),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign head_data   = fifo_rdata[REG_WIDTH-1:0];
   assign head_sel    = fifo_rdata[REG_WIDTH +: 2];
   assign cs_any_c    = ser_att_cs | ser_del_cs;
   assign cmd_ready   = !fifo_full;
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;
   assign ser_data    = ser_data_q;
   assign ser_ld      = ser_ld_q;
   assign ser_sel     = ser_sel_q;
   assign done_pulse  = done_pulse_q;
   assign err_timeout = err_timeout_q;
   assign err_bad_sel = err_bad_sel_q;

   // Next-state, counters and serializer-facing outputs
   always_comb begin
      state_d       = state_q;
      ld_cnt_d      = ld_cnt_q;
      to_cnt_d      = to_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      ser_data_d    = ser_data_q;
      ser_ld_d      = ser_ld_q;
      ser_sel_d     = ser_sel_q;
      done_pulse_d  = 1'b0;
      fifo_pop_c    = 1'b0;
      set_timeout_c = 1'b0;
      set_bad_sel_c = 1'b0;
      enter_gap_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Head must have been visible for a cycle, giving a two-edge push-to-ld latency
            if (head_seen_q && !fifo_empty) begin
               fifo_pop_c = 1'b1;
               if (head_sel == SEL_NONE) begin
                  set_bad_sel_c = 1'b1;
               end else begin
                  ser_data_d = head_data;
                  ser_sel_d  = head_sel;
                  ser_ld_d   = 1'b1;
                  ld_cnt_d   = '0;
                  state_d    = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            // CS is ignored here; the serializer cannot finish while ld is high
            if (ld_cnt_q == LD_LAST) begin
               ser_ld_d = 1'b0;
               to_cnt_d = '0;
               state_d  = ST_WAIT_CS;
            end else begin
               ld_cnt_d = ld_cnt_q + LD_W'(1);
            end
         end
         ST_WAIT_CS: begin
            if (cs_any_c) begin
               to_cnt_d = '0;
               state_d  = ST_WAIT_CS_LOW;
            end else if (to_cnt_q == TO_LAST) begin
               set_timeout_c = 1'b1;
               enter_gap_c   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_WAIT_CS_LOW: begin
            if (!cs_any_c) begin
               done_pulse_d = 1'b1;
               enter_gap_c  = 1'b1;
            end else if (to_cnt_q == TO_LAST) begin
               set_timeout_c = 1'b1;
               enter_gap_c   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Select is released only once the CS pulse is over (or abandoned)
      if (enter_gap_c) begin
         state_d   = ST_GAP;
         ser_sel_d = SEL_NONE;
         gap_cnt_d = '0;
      end

      // Sticky errors: a new event wins over a simultaneous clear
      err_timeout_d = set_timeout_c | (err_timeout_q & ~err_clear);
      err_bad_sel_d = set_bad_sel_c | (err_bad_sel_q & ~err_clear);
      head_seen_d   = !fifo_empty && !fifo_pop_c;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         ld_cnt_q      <= '0;
         to_cnt_q      <= '0;
         gap_cnt_q     <= '0;
         ser_data_q    <= '0;
         ser_ld_q      <= 1'b0;
         ser_sel_q     <= SEL_NONE;
         done_pulse_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         err_bad_sel_q <= 1'b0;
         head_seen_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ld_cnt_q      <= ld_cnt_d;
         to_cnt_q      <= to_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         ser_data_q    <= ser_data_d;
         ser_ld_q      <= ser_ld_d;
         ser_sel_q     <= ser_sel_d;
         done_pulse_q  <= done_pulse_d;
         err_timeout_q <= err_timeout_d;
         err_bad_sel_q <= err_bad_sel_d;
         head_seen_q   <= head_seen_d;
      end
   end

endmodule
